smem_result_writer: RTL and testbench

Write-side counterpart of the read-loading RAM in the SMEM pipeline. Accepts one 256-bit SMEM result record per cycle from the pipeline tail and packs two records per 512-bit cache line. Lines are buffered in a line FIFO and returned to the host write channel with a valid/ready handshake. Tracks per-read end markers, flushes the last partial line, and signals batch completion once every line has drained.

---
 rtl/smem_result_writer_pkg.sv | 50 +++++
 rtl/smem_result_writer_line_fifo.sv | 61 ++++++
 rtl/smem_result_writer.sv | 174 +++++++++++++++++
 tb/tb_smem_result_writer.sv | 418 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/smem_result_writer_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | smem_result_writer_pkg: record layout, FSM encoding and record packing.   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package smem_result_writer_pkg;

    localparam int CL             = 512;
    localparam int READ_NUM_WIDTH = 8;
    localparam int REC_W          = 256;

    localparam int X0_LSB       = 0;
    localparam int X1_LSB       = 64;
    localparam int X2_LSB       = 128;
    localparam int INFO_LSB     = 192;
    localparam int INFO_W       = 55;
    localparam int END_FLAG_BIT = 247;
    localparam int READ_NUM_LSB = 248;

    typedef logic [3:0] state_t;

    localparam state_t ST_COLLECT = 4'b0001;
    localparam state_t ST_FLUSH   = 4'b0010;
    localparam state_t ST_DRAIN   = 4'b0100;
    localparam state_t ST_DONE    = 4'b1000;

    // Terminators carry only read index and end flag; interval fields are forced to zero.
    function automatic logic [REC_W-1:0] pack_record(
        input logic [63:0]               x0,
        input logic [63:0]               x1,
        input logic [63:0]               x2,
        input logic [63:0]               info,
        input logic                      end_flag,
        input logic [READ_NUM_WIDTH-1:0] read_num
    );
        logic [REC_W-1:0] rec;
        rec = '0;
        if (!end_flag) begin
            rec[X0_LSB +: 64]       = x0;
            rec[X1_LSB +: 64]       = x1;
            rec[X2_LSB +: 64]       = x2;
            rec[INFO_LSB +: INFO_W] = info[INFO_W-1:0];
        end
        rec[END_FLAG_BIT]                       = end_flag;
        rec[READ_NUM_LSB +: READ_NUM_WIDTH]     = read_num;
        return rec;
    endfunction

endpackage
`default_nettype wire

// File: rtl/smem_result_writer_line_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | line_fifo: first-word fall-through synchronous FIFO with occupancy count. |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module line_fifo #(
    parameter int WIDTH = 513,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       valid,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] C_DEPTH = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_pop;
    logic             w_push;

    // A pop on a full FIFO frees the slot the concurrent push uses.
    assign w_pop  = pop && (r_count != '0);
    assign w_push = push && ((r_count != C_DEPTH) || w_pop);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= push_data;
    end

    assign pop_data = r_mem[r_rd_ptr];
    assign valid    = (r_count != '0);
    assign full     = (r_count == C_DEPTH);
    assign count    = r_count;

endmodule
`default_nettype wire

// File: rtl/smem_result_writer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | smem_result_writer: packs SMEM records two per line and drains to host.   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module smem_result_writer #(
    parameter int FIFO_DEPTH     = 16,
    parameter int CL             = 512,
    parameter int READ_NUM_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [8:0]                batch_size,
    input  logic                      rec_valid,
    input  logic                      rec_end,
    input  logic [READ_NUM_WIDTH-1:0] rec_read_num,
    input  logic [63:0]               rec_ik_x0,
    input  logic [63:0]               rec_ik_x1,
    input  logic [63:0]               rec_ik_x2,
    input  logic [63:0]               rec_ik_info,
    output logic                      stall,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [CL-1:0]             out_data,
    output logic [15:0]               out_addr,
    output logic                      out_last,
    output logic                      batch_done,
    output logic                      overflow_err
);

    import smem_result_writer_pkg::*;

    localparam int HALF_W = CL / 2;
    localparam int LINE_W = CL + 1;
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] C_STALL_LVL = CNT_W'(FIFO_DEPTH - 2);
    localparam logic [CNT_W-1:0] C_ONE       = CNT_W'(1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [HALF_W-1:0] r_half;
    logic              r_half_vld;
    logic [8:0]        r_end_cnt;
    logic [15:0]       r_addr;
    logic              r_ovf;

    logic [HALF_W-1:0] w_rec;
    logic              w_accept;
    logic              w_pop_fire;
    logic              w_fifo_room;
    logic              w_drop;
    logic              w_take;
    logic              w_end_take;
    logic [8:0]        w_end_cnt_nxt;
    logic              w_final_end;
    logic              w_flush_push;
    logic              w_drained;
    logic              w_push;
    logic [LINE_W-1:0] w_push_data;
    logic [LINE_W-1:0] w_fifo_data;
    logic              w_fifo_valid;
    logic              w_fifo_full;
    logic [CNT_W-1:0]  w_fifo_count;

    assign w_rec = pack_record(rec_ik_x0, rec_ik_x1, rec_ik_x2, rec_ik_info,
                               rec_end, rec_read_num);

    assign w_accept      = rec_valid && (r_state == ST_COLLECT);
    assign w_pop_fire    = w_fifo_valid && out_ready;
    assign w_fifo_room   = !w_fifo_full || w_pop_fire;
    // Only a line-completing record needs a slot; a first half always fits.
    assign w_drop        = w_accept && r_half_vld && !w_fifo_room;
    assign w_take        = w_accept && !w_drop;
    assign w_end_take    = w_take && rec_end;
    assign w_end_cnt_nxt = r_end_cnt + {8'd0, w_end_take};
    assign w_final_end   = w_end_take && (w_end_cnt_nxt == batch_size) && (batch_size != 9'd0);
    assign w_flush_push  = (r_state == ST_FLUSH) && r_half_vld && w_fifo_room;
    // True when the FIFO is empty at the end of this cycle.
    assign w_drained     = (w_fifo_count == '0) || ((w_fifo_count == C_ONE) && w_pop_fire);

    always_ff @(posedge clk) begin
        if (!reset_n) r_state <= ST_COLLECT;
        else          r_state <= w_state_nxt;
    end

    // Leaving FLUSH straight to DONE keeps batch_done one cycle after the last transfer.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_COLLECT: if (w_final_end) w_state_nxt = ST_FLUSH;
            ST_FLUSH: begin
                if (r_half_vld) begin
                    if (w_flush_push) w_state_nxt = ST_DRAIN;
                end else if (w_drained) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN:   if (w_drained) w_state_nxt = ST_DONE;
            ST_DONE:    w_state_nxt = ST_DONE;
            default:    w_state_nxt = ST_COLLECT;
        endcase
    end

    always_comb begin
        w_push      = 1'b0;
        w_push_data = '0;
        case (r_state)
            ST_COLLECT: begin
                if (w_take && r_half_vld) begin
                    w_push      = 1'b1;
                    w_push_data = {w_final_end, w_rec, r_half};
                end
            end
            ST_FLUSH: begin
                if (w_flush_push) begin
                    w_push      = 1'b1;
                    w_push_data = {1'b1, {HALF_W{1'b0}}, r_half};
                end
            end
            default: ;
        endcase
        stall      = (w_fifo_count >= C_STALL_LVL) || (r_state != ST_COLLECT);
        batch_done = (r_state == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_half     <= '0;
            r_half_vld <= 1'b0;
            r_end_cnt  <= '0;
            r_addr     <= '0;
            r_ovf      <= 1'b0;
        end else begin
            if (w_take) begin
                if (r_half_vld) begin
                    r_half_vld <= 1'b0;
                end else begin
                    r_half     <= w_rec;
                    r_half_vld <= 1'b1;
                end
            end
            if (w_flush_push) r_half_vld <= 1'b0;
            if (w_end_take)   r_end_cnt  <= w_end_cnt_nxt;
            if (w_pop_fire)   r_addr     <= r_addr + 16'd1;
            if (w_drop)       r_ovf      <= 1'b1;
        end
    end

    line_fifo #(
        .WIDTH (LINE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (w_push),
        .push_data (w_push_data),
        .pop       (out_ready),
        .pop_data  (w_fifo_data),
        .valid     (w_fifo_valid),
        .full      (w_fifo_full),
        .count     (w_fifo_count)
    );

    // Storage is not reset, so data and marker are masked while no line is present.
    assign out_valid    = w_fifo_valid;
    assign out_data     = w_fifo_valid ? w_fifo_data[CL-1:0] : '0;
    assign out_last     = w_fifo_valid && w_fifo_data[CL];
    assign out_addr     = r_addr;
    assign overflow_err = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_smem_result_writer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_smem_result_writer: directed self-checking bench for the result writer.|
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_smem_result_writer;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [8:0]   batch_size = '0;
    logic         rec_valid = 1'b0;
    logic         rec_end = 1'b0;
    logic [7:0]   rec_read_num = '0;
    logic [63:0]  rec_ik_x0 = '0;
    logic [63:0]  rec_ik_x1 = '0;
    logic [63:0]  rec_ik_x2 = '0;
    logic [63:0]  rec_ik_info = '0;
    logic         stall;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [511:0] out_data;
    logic [15:0]  out_addr;
    logic         out_last;
    logic         batch_done;
    logic         overflow_err;

    int n_checks = 0;
    int n_fails  = 0;
    int cyc = 0;
    int done_cyc = -1;
    int last_xfer_cyc = -1;

    logic [511:0] q_data[$];
    logic [15:0]  q_addr[$];
    logic         q_last[$];

    always #5 clk = ~clk;

    smem_result_writer #(
        .FIFO_DEPTH     (16),
        .CL             (512),
        .READ_NUM_WIDTH (8)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .batch_size   (batch_size),
        .rec_valid    (rec_valid),
        .rec_end      (rec_end),
        .rec_read_num (rec_read_num),
        .rec_ik_x0    (rec_ik_x0),
        .rec_ik_x1    (rec_ik_x1),
        .rec_ik_x2    (rec_ik_x2),
        .rec_ik_info  (rec_ik_info),
        .stall        (stall),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_addr     (out_addr),
        .out_last     (out_last),
        .batch_done   (batch_done),
        .overflow_err (overflow_err)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Transfers are logged mid-cycle, before the edge that completes them.
    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                q_data.push_back(out_data);
                q_addr.push_back(out_addr);
                q_last.push_back(out_last);
                last_xfer_cyc <= cyc;
            end
            if (batch_done === 1'b1 && done_cyc < 0) done_cyc <= cyc;
        end
    end

    // Expected 256-bit record image for the stimulus that send() drives.
    function automatic logic [255:0] mk(input logic [63:0] x0, input logic e, input logic [7:0] rn);
        logic [255:0] r;
        if (e) begin
            r = {rn, 1'b1, 55'd0, 192'd0};
        end else begin
            r[63:0]    = x0;
            r[127:64]  = x0 + 64'd100;
            r[191:128] = x0 + 64'd200;
            r[255:192] = {rn, 1'b0, x0[54:0]};
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [63:0] x0, input logic e, input logic [7:0] rn);
        rec_valid    = 1'b1;
        rec_end      = e;
        rec_read_num = rn;
        rec_ik_x0    = x0;
        rec_ik_x1    = x0 + 64'd100;
        rec_ik_x2    = x0 + 64'd200;
        rec_ik_info  = 64'hFF80_0000_0000_0000 | x0;
        tick();
        rec_valid = 1'b0;
        rec_end   = 1'b0;
    endtask

    task automatic clear_log();
        q_data.delete();
        q_addr.delete();
        q_last.delete();
        done_cyc = -1;
        last_xfer_cyc = -1;
    endtask

    task automatic do_reset(input logic [8:0] bs, input logic rdy);
        reset_n    = 1'b0;
        rec_valid  = 1'b0;
        rec_end    = 1'b0;
        batch_size = bs;
        out_ready  = rdy;
        tick();
        tick();
        clear_log();
        reset_n = 1'b1;
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 200; i++) begin
            if (batch_done === 1'b1) break;
            tick();
        end
        tick();
        n_checks++;
        if (batch_done !== 1'b1) begin
            n_fails++;
            $display("FAIL %s_done: batch_done=%b expected 1", name, batch_done);
        end
        n_checks++;
        if (done_cyc != last_xfer_cyc + 1) begin
            n_fails++;
            $display("FAIL %s_done_timing: done cycle %0d, expected %0d", name, done_cyc, last_xfer_cyc + 1);
        end
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int i = 0; i < 64; i++) begin
            if (out_valid !== 1'b1) break;
            tick();
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        do_reset(9'd1, 1'b0);
        n_checks++;
        if ({stall, out_valid, out_last, batch_done, overflow_err} !== 5'b0) begin
            n_fails++;
            $display("FAIL reset_flags: got %b expected 00000",
                     {stall, out_valid, out_last, batch_done, overflow_err});
        end
        n_checks++;
        if (out_data !== 512'd0) begin
            n_fails++;
            $display("FAIL reset_data: got %h expected 0", out_data);
        end
        n_checks++;
        if (out_addr !== 16'd0) begin
            n_fails++;
            $display("FAIL reset_addr: got %0d expected 0", out_addr);
        end
    endtask

    task automatic test_single_read();
        do_reset(9'd1, 1'b1);
        send(64'd1, 1'b0, 8'd0);
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fails++;
            $display("FAIL single_half_valid: out_valid=%b expected 0", out_valid);
        end
        send(64'd2, 1'b0, 8'd0);
        n_checks++;
        if (out_valid !== 1'b1 || out_addr !== 16'd0) begin
            n_fails++;
            $display("FAIL single_latency: valid=%b addr=%0d expected 1/0", out_valid, out_addr);
        end
        n_checks++;
        if (out_data !== {mk(64'd2, 1'b0, 8'd0), mk(64'd1, 1'b0, 8'd0)}) begin
            n_fails++;
            $display("FAIL single_line0: got %h expected %h", out_data,
                     {mk(64'd2, 1'b0, 8'd0), mk(64'd1, 1'b0, 8'd0)});
        end
        send(64'hDEAD, 1'b1, 8'd0);
        wait_done("single");
        n_checks++;
        if (q_data.size() != 2) begin
            n_fails++;
            $display("FAIL single_count: got %0d lines expected 2", q_data.size());
        end else begin
            n_checks++;
            if (q_data[1] !== {256'd0, mk(64'd0, 1'b1, 8'd0)}) begin
                n_fails++;
                $display("FAIL single_line1: got %h expected %h", q_data[1], {256'd0, mk(64'd0, 1'b1, 8'd0)});
            end
            n_checks++;
            if ({q_last[0], q_last[1], q_addr[1]} !== {2'b01, 16'd1}) begin
                n_fails++;
                $display("FAIL single_last_addr: got last=%b%b addr1=%0d expected 01/1",
                         q_last[0], q_last[1], q_addr[1]);
            end
        end
    endtask

    task automatic test_pair_end();
        do_reset(9'd2, 1'b1);
        send(64'd5, 1'b0, 8'd0);
        send(64'hBEEF, 1'b1, 8'd0);
        send(64'd6, 1'b0, 8'd1);
        send(64'hBEEF, 1'b1, 8'd1);
        wait_done("pair");
        n_checks++;
        if (q_data.size() != 2) begin
            n_fails++;
            $display("FAIL pair_count: got %0d lines expected 2", q_data.size());
        end else begin
            n_checks++;
            if (q_data[0] !== {mk(64'd0, 1'b1, 8'd0), mk(64'd5, 1'b0, 8'd0)}) begin
                n_fails++;
                $display("FAIL pair_line0: got %h expected %h", q_data[0],
                         {mk(64'd0, 1'b1, 8'd0), mk(64'd5, 1'b0, 8'd0)});
            end
            n_checks++;
            if (q_data[1] !== {mk(64'd0, 1'b1, 8'd1), mk(64'd6, 1'b0, 8'd1)}) begin
                n_fails++;
                $display("FAIL pair_line1: got %h expected %h", q_data[1],
                         {mk(64'd0, 1'b1, 8'd1), mk(64'd6, 1'b0, 8'd1)});
            end
            n_checks++;
            if ({q_last[0], q_last[1]} !== 2'b01) begin
                n_fails++;
                $display("FAIL pair_last: got %b%b expected 01", q_last[0], q_last[1]);
            end
        end
    endtask

    task automatic test_stall();
        int sent;
        do_reset(9'd0, 1'b0);
        sent = 0;
        for (int i = 0; i < 40; i++) begin
            if (stall === 1'b1) break;
            send(64'(i + 1), 1'b0, 8'd2);
            sent++;
        end
        n_checks++;
        if (sent != 28 || stall !== 1'b1) begin
            n_fails++;
            $display("FAIL stall_level: records before stall %0d stall=%b expected 28/1", sent, stall);
        end
        n_checks++;
        if (out_valid !== 1'b1 || out_addr !== 16'd0 ||
            out_data !== {mk(64'd2, 1'b0, 8'd2), mk(64'd1, 1'b0, 8'd2)}) begin
            n_fails++;
            $display("FAIL stall_hold: valid=%b addr=%0d data=%h", out_valid, out_addr, out_data);
        end
        n_checks++;
        if (overflow_err !== 1'b0) begin
            n_fails++;
            $display("FAIL stall_ovf: got %b expected 0", overflow_err);
        end
        drain();
        n_checks++;
        if (q_data.size() != 14) begin
            n_fails++;
            $display("FAIL stall_drain_count: got %0d expected 14", q_data.size());
        end else begin
            n_checks++;
            if (q_addr[13] !== 16'd13 || q_data[13] !== {mk(64'd28, 1'b0, 8'd2), mk(64'd27, 1'b0, 8'd2)}) begin
                n_fails++;
                $display("FAIL stall_drain_tail: addr=%0d data=%h", q_addr[13], q_data[13]);
            end
        end
    endtask

    task automatic test_overflow();
        do_reset(9'd0, 1'b0);
        for (int i = 1; i <= 33; i++) send(64'(i), 1'b0, 8'd3);
        n_checks++;
        if (overflow_err !== 1'b0) begin
            n_fails++;
            $display("FAIL ovf_half_ok: got %b expected 0", overflow_err);
        end
        send(64'd34, 1'b0, 8'd3);
        n_checks++;
        if (overflow_err !== 1'b1 || stall !== 1'b1) begin
            n_fails++;
            $display("FAIL ovf_set: ovf=%b stall=%b expected 1/1", overflow_err, stall);
        end
        drain();
        n_checks++;
        if (q_data.size() != 16) begin
            n_fails++;
            $display("FAIL ovf_count: got %0d lines expected 16", q_data.size());
        end
        send(64'd35, 1'b0, 8'd3);
        drain();
        n_checks++;
        if (q_data.size() != 17) begin
            n_fails++;
            $display("FAIL ovf_resume_count: got %0d lines expected 17", q_data.size());
        end else begin
            n_checks++;
            if (q_data[16] !== {mk(64'd35, 1'b0, 8'd3), mk(64'd33, 1'b0, 8'd3)}) begin
                n_fails++;
                $display("FAIL ovf_half_kept: got %h expected %h", q_data[16],
                         {mk(64'd35, 1'b0, 8'd3), mk(64'd33, 1'b0, 8'd3)});
            end
        end
        n_checks++;
        if (overflow_err !== 1'b1) begin
            n_fails++;
            $display("FAIL ovf_sticky: got %b expected 1", overflow_err);
        end
    endtask

    task automatic test_full_pushpop();
        do_reset(9'd0, 1'b0);
        for (int i = 1; i <= 33; i++) send(64'(i), 1'b0, 8'd4);
        out_ready = 1'b1;
        send(64'd34, 1'b0, 8'd4);
        out_ready = 1'b0;
        n_checks++;
        if (overflow_err !== 1'b0 || stall !== 1'b1 || out_addr !== 16'd1) begin
            n_fails++;
            $display("FAIL full_pushpop: ovf=%b stall=%b addr=%0d expected 0/1/1",
                     overflow_err, stall, out_addr);
        end
        drain();
        n_checks++;
        if (q_data.size() != 17) begin
            n_fails++;
            $display("FAIL full_count: got %0d lines expected 17", q_data.size());
        end else begin
            n_checks++;
            if (q_data[16] !== {mk(64'd34, 1'b0, 8'd4), mk(64'd33, 1'b0, 8'd4)} ||
                q_data[0] !== {mk(64'd2, 1'b0, 8'd4), mk(64'd1, 1'b0, 8'd4)}) begin
                n_fails++;
                $display("FAIL full_data: first=%h last=%h", q_data[0], q_data[16]);
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset(9'd2, 1'b0);
        send(64'd1, 1'b0, 8'd0);
        send(64'd2, 1'b0, 8'd0);
        send(64'd3, 1'b0, 8'd0);
        send(64'hAAAA, 1'b1, 8'd0);
        send(64'd4, 1'b0, 8'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        reset_n    = 1'b0;
        batch_size = 9'd1;
        tick();
        n_checks++;
        if ({stall, out_valid, out_last, batch_done, overflow_err} !== 5'b0 ||
            out_addr !== 16'd0 || out_data !== 512'd0) begin
            n_fails++;
            $display("FAIL midreset_outputs: flags=%b addr=%0d data=%h",
                     {stall, out_valid, out_last, batch_done, overflow_err}, out_addr, out_data);
        end
        clear_log();
        reset_n   = 1'b1;
        out_ready = 1'b1;
        send(64'd7, 1'b0, 8'd3);
        send(64'hCCCC, 1'b1, 8'd3);
        wait_done("midreset");
        n_checks++;
        if (q_data.size() != 1) begin
            n_fails++;
            $display("FAIL midreset_count: got %0d lines expected 1", q_data.size());
        end else begin
            n_checks++;
            if (q_addr[0] !== 16'd0 || q_last[0] !== 1'b1 ||
                q_data[0] !== {mk(64'd0, 1'b1, 8'd3), mk(64'd7, 1'b0, 8'd3)}) begin
                n_fails++;
                $display("FAIL midreset_line: addr=%0d last=%b data=%h", q_addr[0], q_last[0], q_data[0]);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_read();
        test_pair_end();
        test_stall();
        test_overflow();
        test_full_pushpop();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
